mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory/MIO arbiter between instruction fetch and load/store.
// Alternates on contention, holds the bus until MIO_ready or timeout, and stalls the pipeline.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_valid,
  input  logic [31:0] bus_rdata,
  input  logic        MIO_ready,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 32'd1);

  state_t      stateReg, stateNext;
  logic        lastGrantReg, lastGrantNext;   // 1 = DATA was granted last
  logic [31:0] busAddrReg, busAddrNext;
  logic [31:0] busWdataReg, busWdataNext;
  logic        busWeReg, busWeNext;
  logic        busValidReg, busValidNext;
  logic [31:0] ifRdataReg, ifRdataNext;
  logic [31:0] dRdataReg, dRdataNext;
  logic        ifAckReg, ifAckNext;
  logic        dAckReg, dAckNext;
  logic        busErrReg, busErrNext;
  logic [15:0] waitCntReg, waitCntNext;

  logic        ifElig, dElig, pickData, finish;
  logic [31:0] retData;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      lastGrantReg <= 1'b0;
      busAddrReg   <= '0;
      busWdataReg  <= '0;
      busWeReg     <= 1'b0;
      busValidReg  <= 1'b0;
      ifRdataReg   <= '0;
      dRdataReg    <= '0;
      ifAckReg     <= 1'b0;
      dAckReg      <= 1'b0;
      busErrReg    <= 1'b0;
      waitCntReg   <= '0;
    end else begin
      stateReg     <= stateNext;
      lastGrantReg <= lastGrantNext;
      busAddrReg   <= busAddrNext;
      busWdataReg  <= busWdataNext;
      busWeReg     <= busWeNext;
      busValidReg  <= busValidNext;
      ifRdataReg   <= ifRdataNext;
      dRdataReg    <= dRdataNext;
      ifAckReg     <= ifAckNext;
      dAckReg      <= dAckNext;
      busErrReg    <= busErrNext;
      waitCntReg   <= waitCntNext;
    end
  end

  // A port whose ack is high this cycle is still retiring and must not be regranted.
  assign ifElig   = if_req & ~ifAckReg;
  assign dElig    = d_req & ~dAckReg;
  assign pickData = dElig & (~ifElig | ~lastGrantReg);
  assign finish   = MIO_ready | (waitCntReg == WAIT_LAST);
  assign retData  = MIO_ready ? bus_rdata : ERR_DATA;

  always_comb begin
    stateNext     = stateReg;
    lastGrantNext = lastGrantReg;
    busAddrNext   = busAddrReg;
    busWdataNext  = busWdataReg;
    busWeNext     = busWeReg;
    busValidNext  = busValidReg;
    ifRdataNext   = ifRdataReg;
    dRdataNext    = dRdataReg;
    ifAckNext     = 1'b0;
    dAckNext      = 1'b0;
    busErrNext    = 1'b0;
    waitCntNext   = waitCntReg;
    case (stateReg)
      IDLE: begin
        if (ifElig | dElig) begin
          busValidNext  = 1'b1;
          waitCntNext   = '0;
          lastGrantNext = pickData;
          if (pickData) begin
            stateNext    = DATA;
            busAddrNext  = d_addr;
            busWdataNext = d_wdata;
            busWeNext    = d_we;
          end else begin
            stateNext   = FETCH;
            busAddrNext = if_addr;
            busWeNext   = 1'b0;
          end
        end
      end
      FETCH, DATA: begin
        if (finish) begin
          // Ready on the last allowed cycle counts as a normal completion.
          stateNext    = IDLE;
          busValidNext = 1'b0;
          busWeNext    = 1'b0;
          busErrNext   = ~MIO_ready;
          if (stateReg == FETCH) begin
            ifAckNext   = 1'b1;
            ifRdataNext = retData;
          end else begin
            dAckNext = 1'b1;
            if (!busWeReg) dRdataNext = retData;
          end
        end else begin
          waitCntNext = waitCntReg + 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign if_rdata  = ifRdataReg;
  assign if_ack    = ifAckReg;
  assign d_rdata   = dRdataReg;
  assign d_ack     = dAckReg;
  assign bus_addr  = busAddrReg;
  assign bus_wdata = busWdataReg;
  assign bus_we    = busWeReg;
  assign bus_valid = busValidReg;
  assign bus_err   = busErrReg;
  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the arbiter (TIMEOUT=4, ERR_DATA=DEADBEEF).
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, MIO_ready;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic        if_ack, d_ack, bus_we, bus_valid, stall, bus_err;

  int nVec = 0;
  int nMis = 0;

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_valid(bus_valid),
    .bus_rdata(bus_rdata), .MIO_ready(MIO_ready), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; MIO_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; bus_rdata = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // transaction-level model state
  bit          mBusy, mWho, mWe, mLast, ready;
  bit          eIfAck, eDAck, eErr, nIfAck, nDAck, nErr, ifE, dE;
  int          mWait, mDelay;
  logic [31:0] mAddr, mWdata, eIfRd, eDRd, ret;

  initial begin
    // ---- reset state and single fetch ----
    doReset();
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_ifrd", if_rdata, 0);
    chk("rst_drd", d_rdata, 0);
    if_req = 1; if_addr = 32'h40; MIO_ready = 1; bus_rdata = 32'h2008_0005;
    #1 chk("f_stall0", 32'(stall), 1);
    tick();
    chk("f_valid1", 32'(bus_valid), 1);
    chk("f_addr1", bus_addr, 32'h40);
    chk("f_we1", 32'(bus_we), 0);
    chk("f_ack1", 32'(if_ack), 0);
    chk("f_stall1", 32'(stall), 1);
    tick();
    chk("f_ack2", 32'(if_ack), 1);
    chk("f_rdata2", if_rdata, 32'h2008_0005);
    chk("f_valid2", 32'(bus_valid), 0);
    chk("f_stall2", 32'(stall), 0);
    tick();                         // if_req held one cycle past ack
    chk("noregrant_valid", 32'(bus_valid), 0);
    chk("noregrant_ack", 32'(if_ack), 0);
    if_req = 0;
    tick();
    chk("noregrant_valid2", 32'(bus_valid), 0);

    // ---- contention alternates DATA, FETCH, DATA, FETCH ----
    doReset();
    d_req = 1; d_we = 0; d_addr = 32'h1000; if_req = 1; if_addr = 32'h2000;
    MIO_ready = 1; bus_rdata = 32'h1111_2222;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        chk($sformatf("alt_valid%0d", k), 32'(bus_valid), 1);
        chk($sformatf("alt_addr%0d", k), bus_addr, (((k - 1) / 2) % 2 == 0) ? 32'h1000 : 32'h2000);
      end else begin
        chk($sformatf("alt_valid%0d", k), 32'(bus_valid), 0);
      end
    end
    chk("alt_ifack", 32'(if_ack), 1);
    chk("alt_ifrd", if_rdata, 32'h1111_2222);
    chk("alt_drd", d_rdata, 32'h1111_2222);
    if_req = 0; d_req = 0;
    tick();

    // ---- store with three wait cycles ----
    MIO_ready = 0; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("st_valid%0d", k), 32'(bus_valid), 1);
      chk($sformatf("st_addr%0d", k), bus_addr, 32'h100);
      chk($sformatf("st_we%0d", k), 32'(bus_we), 1);
      chk($sformatf("st_wdata%0d", k), bus_wdata, 32'hCAFE_F00D);
      chk($sformatf("st_ack%0d", k), 32'(d_ack), 0);
      if (k == 4) MIO_ready = 1;
      tick();
    end
    chk("st_ack", 32'(d_ack), 1);
    chk("st_valid_off", 32'(bus_valid), 0);
    chk("st_we_off", 32'(bus_we), 0);
    chk("st_err", 32'(bus_err), 0);
    chk("st_drd_kept", d_rdata, 32'h1111_2222);
    d_req = 0; d_we = 0; MIO_ready = 0;
    tick();

    // ---- load timeout ----
    d_req = 1; d_addr = 32'h200;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_valid%0d", k), 32'(bus_valid), 1);
      chk($sformatf("to_ack%0d", k), 32'(d_ack), 0);
      tick();
    end
    chk("to_valid_off", 32'(bus_valid), 0);
    chk("to_ack", 32'(d_ack), 1);
    chk("to_err", 32'(bus_err), 1);
    chk("to_drd", d_rdata, ERRD);
    d_req = 0;
    tick();
    chk("to_err_pulse", 32'(bus_err), 0);
    chk("to_ack_pulse", 32'(d_ack), 0);

    // ---- ready on the last allowed cycle wins ----
    d_req = 1; d_addr = 32'h204;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("late_valid%0d", k), 32'(bus_valid), 1);
      if (k == 4) begin MIO_ready = 1; bus_rdata = 32'h5A5A_1234; end
      tick();
    end
    chk("late_ack", 32'(d_ack), 1);
    chk("late_err", 32'(bus_err), 0);
    chk("late_drd", d_rdata, 32'h5A5A_1234);
    d_req = 0; MIO_ready = 0;
    tick();

    // ---- reset in the middle of a fetch ----
    if_req = 1; if_addr = 32'h300;
    tick();
    chk("mr_valid1", 32'(bus_valid), 1);
    tick();
    rst = 1;
    tick();
    chk("mr_valid", 32'(bus_valid), 0);
    chk("mr_addr", bus_addr, 0);
    chk("mr_ack", 32'(if_ack), 0);
    chk("mr_err", 32'(bus_err), 0);
    chk("mr_ifrd", if_rdata, 0);
    chk("mr_drd", d_rdata, 0);
    rst = 0;
    tick();
    chk("mr_regrant", 32'(bus_valid), 1);
    chk("mr_regrant_addr", bus_addr, 32'h300);
    MIO_ready = 1; bus_rdata = 32'h0BAD_CAFE;
    tick();
    chk("mr_ack2", 32'(if_ack), 1);
    chk("mr_ifrd2", if_rdata, 32'h0BAD_CAFE);
    if_req = 0; MIO_ready = 0;
    tick();

    // ---- randomized traffic against the model ----
    doReset();
    mBusy = 0; mLast = 0; eIfAck = 0; eDAck = 0; eErr = 0; eIfRd = 0; eDRd = 0;
    mWait = 0; mDelay = 0; mWho = 0; mWe = 0; mAddr = 0; mWdata = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_valid", 32'(bus_valid), 32'(mBusy));
      if (mBusy) begin
        chk("r_addr", bus_addr, mAddr);
        chk("r_we", 32'(bus_we), 32'(mWe));
        if (mWe) chk("r_wdata", bus_wdata, mWdata);
      end
      chk("r_ifack", 32'(if_ack), 32'(eIfAck));
      chk("r_dack", 32'(d_ack), 32'(eDAck));
      chk("r_err", 32'(bus_err), 32'(eErr));
      chk("r_ifrd", if_rdata, eIfRd);
      chk("r_drd", d_rdata, eDRd);

      // requesters: drop on ack, otherwise sometimes raise a new request
      if (eIfAck) if_req = 0;
      else if (!if_req && ($urandom % 3 == 0)) begin if_req = 1; if_addr = $urandom; end
      if (eDAck) d_req = 0;
      else if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1; d_we = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end
      ready = mBusy ? (mWait == mDelay) : bit'($urandom % 2);
      MIO_ready = ready;
      bus_rdata = $urandom;
      #1 chk("r_stall", 32'(stall), 32'((if_req & ~eIfAck) | (d_req & ~eDAck)));

      nIfAck = 0; nDAck = 0; nErr = 0;
      if (mBusy) begin
        if (ready || mWait == TO - 1) begin
          ret = ready ? bus_rdata : ERRD;
          nErr = !ready;
          mBusy = 0;
          if (!mWho) begin nIfAck = 1; eIfRd = ret; end
          else begin nDAck = 1; if (!mWe) eDRd = ret; end
        end else begin
          mWait++;
        end
      end else begin
        ifE = if_req && !eIfAck;
        dE  = d_req && !eDAck;
        if (ifE || dE) begin
          mWho   = (ifE && dE) ? !mLast : dE;
          mLast  = mWho;
          mBusy  = 1;
          mWait  = 0;
          mDelay = $urandom_range(0, 5);
          mAddr  = mWho ? d_addr : if_addr;
          mWe    = mWho ? d_we : 1'b0;
          mWdata = d_wdata;
        end
      end
      eIfAck = nIfAck; eDAck = nDAck; eErr = nErr;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
